// File: rtl/fp_pkg.sv
// fp_pkg: shared IEEE-754 single-precision field constants, encodings, FSM state and operand classes
package fp_pkg;
    localparam int EXP_W = 8;
    localparam int FRAC_W = 23;
    localparam int BIAS = 127;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam logic [31:0] PINF = 32'h7F80_0000;
    localparam int FLAG_INV = 2;
    localparam int FLAG_DBZ = 1;
    localparam int FLAG_UF = 0;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
    typedef enum logic [2:0] {CLS_CORE, CLS_NAN, CLS_INF, CLS_ZERO, CLS_POW2} cls_e;
    // Denormals fall into CLS_ZERO: they are flushed before taking the reciprocal.
    function automatic cls_e classify(input logic [EXP_W-1:0] e, input logic [FRAC_W-1:0] f);
        if (e == '1) return (f != '0) ? CLS_NAN : CLS_INF;
        if (e == '0) return CLS_ZERO;
        return (f == '0) ? CLS_POW2 : CLS_CORE;
    endfunction
endpackage

// File: rtl/fp_recip_pack.sv
// fp_recip_pack: renormalises a 1.(WL-1) reciprocal mantissa and packs the IEEE-754 result and flags.
module fp_recip_pack
    import fp_pkg::*;
#(
    parameter int WL = 24
) (
    input  logic              sign_i,
    input  logic [EXP_W-1:0]  exp_i,
    input  logic [WL-1:0]     mant_i,
    input  cls_e              cls_i,
    output logic [31:0]       data_o,
    output logic [2:0]        flags_o
);
    localparam logic signed [9:0] E_TOP = 10'(2 * BIAS);
    logic [WL-1:0] ext;
    logic signed [9:0] e_pow2, e_res;
    logic [FRAC_W-1:0] f_res;
    // ext holds the mantissa shifted left by one, so both renormalisation cases slice the same vector.
    always_comb begin
        ext = {mant_i[WL-2:0], 1'b0};
        e_pow2 = E_TOP - $signed({2'b00, exp_i});
        e_res = (cls_i == CLS_POW2 || mant_i[WL-1]) ? e_pow2 : e_pow2 - 10'sd1;
        f_res = (cls_i == CLS_POW2) ? '0 : (mant_i[WL-1] ? ext[WL-1 -: FRAC_W] : ext[WL-2 -: FRAC_W]);
        data_o = '0;
        flags_o = '0;
        case (cls_i)
            CLS_NAN: begin
                data_o = QNAN;
                flags_o[FLAG_INV] = 1'b1;
            end
            CLS_INF: data_o = {sign_i, 31'b0};
            CLS_ZERO: begin
                data_o = PINF | {sign_i, 31'b0};
                flags_o[FLAG_DBZ] = 1'b1;
            end
            default: begin
                data_o = (e_res <= 10'sd0) ? {sign_i, 31'b0} : {sign_i, e_res[7:0], f_res};
                flags_o[FLAG_UF] = (e_res <= 10'sd0);
            end
        endcase
    end
endmodule

// File: rtl/fp_recip_issue.sv
// fp_recip_issue: single-precision 1/x front/back end around a multicycle reciprocal mantissa core.
// Specials and exact powers of two bypass the core; one operation in flight.
module fp_recip_issue
    import fp_pkg::*;
#(
    parameter int WL = 24,
    parameter int CORE_LAT = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          CE,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_data,
    output logic [2:0]    out_flags,
    output logic [WL-1:0] core_din,
    input  logic [WL-1:0] core_dout,
    output logic          core_nrst,
    output logic          core_ce
);
    localparam int PAD = WL - 24;
    localparam logic [3:0] LAST = 4'(CORE_LAT - 1);
    state_e state_q;
    logic [3:0] cnt_q;
    logic [WL-1:0] core_din_q;
    logic [31:0] out_data_q;
    logic [2:0] out_flags_q;
    logic sign_q;
    logic [EXP_W-1:0] exp_q;
    cls_e in_cls, pk_cls;
    logic pk_sign;
    logic [EXP_W-1:0] pk_exp;
    logic [31:0] pk_data;
    logic [2:0] pk_flags;
    assign in_cls = classify(in_data[30:23], in_data[22:0]);
    // The packer sees the incoming operand in IDLE and the latched one while the core runs.
    assign pk_cls = (state_q == RUN) ? CLS_CORE : in_cls;
    assign pk_sign = (state_q == RUN) ? sign_q : in_data[31];
    assign pk_exp = (state_q == RUN) ? exp_q : in_data[30:23];
    fp_recip_pack #(.WL(WL)) u_pack (
        .sign_i (pk_sign),
        .exp_i  (pk_exp),
        .mant_i (core_dout),
        .cls_i  (pk_cls),
        .data_o (pk_data),
        .flags_o(pk_flags)
    );
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q <= '0;
            core_din_q <= '0;
            out_data_q <= '0;
            out_flags_q <= '0;
            sign_q <= 1'b0;
            exp_q <= '0;
        end else if (CE) begin
            case (state_q)
                IDLE: if (in_valid) begin
                    sign_q <= in_data[31];
                    exp_q <= in_data[30:23];
                    if (in_cls == CLS_CORE) begin
                        core_din_q <= WL'({1'b1, in_data[22:0]}) << PAD;
                        cnt_q <= '0;
                        state_q <= RUN;
                    end else begin
                        out_data_q <= pk_data;
                        out_flags_q <= pk_flags;
                        state_q <= DONE;
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == LAST) begin
                        out_data_q <= pk_data;
                        out_flags_q <= pk_flags;
                        state_q <= DONE;
                    end
                end
                DONE: if (out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
    assign in_ready = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data = out_data_q;
    assign out_flags = out_flags_q;
    assign core_din = core_din_q;
    // The core is only released while it is computing, so bypass results never wake it.
    assign core_nrst = (state_q == RUN) && !RST;
    assign core_ce = CE;
endmodule

// File: tb/tb_fp_recip_issue.sv
// tb_fp_recip_issue: directed bench with a value-level 1/x model, a behavioural core and a per-cycle output check.
module tb_fp_recip_issue;
    localparam int WL = 24;
    localparam int LAT = 4;
    logic CLK = 1'b0, RST = 1'b1, CE = 1'b1;
    logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
    logic [31:0] in_data = '0, out_data;
    logic [2:0] out_flags;
    logic [WL-1:0] core_din, core_dout;
    logic core_nrst, core_ce;
    logic force_en = 1'b0;
    logic [23:0] force_val = '0;
    logic [3:0] ccnt = '0;
    int cmp = 0, fail = 0;
    logic [31:0] qd[$];
    logic [2:0] qf[$];
    fp_recip_issue #(.WL(WL), .CORE_LAT(LAT)) dut (
        .CLK(CLK), .RST(RST), .CE(CE),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_flags(out_flags),
        .core_din(core_din), .core_dout(core_dout), .core_nrst(core_nrst), .core_ce(core_ce)
    );
    always #5 CLK = ~CLK;
    function automatic logic [23:0] core_recip(input logic [23:0] m);
        longint num;
        num = longint'(1) << 46;
        return (m == 0) ? 24'h0 : 24'(num / longint'(m));
    endfunction
    // Behavioural core: result appears LAT enabled cycles after release, garbage before that.
    always @(posedge CLK) begin
        if (!core_nrst) ccnt <= '0;
        else if (core_ce && ccnt != 4'hF) ccnt <= ccnt + 4'd1;
    end
    assign core_dout = (core_nrst && ccnt >= 4'(LAT - 1)) ? (force_en ? force_val : core_recip(core_din)) : 24'h0F0F0F;
    // Value-level model: 1/x = (cd * 2^-23) * 2^(127-e), renormalised by locating the leading one.
    task automatic model(input logic [31:0] x, input logic [23:0] cd, output logic [31:0] d, output logic [2:0] fl);
        logic s;
        int e, be, p;
        logic [23:0] m;
        s = x[31];
        e = int'(x[30:23]);
        fl = 3'b000;
        if (e == 255 && x[22:0] != 0) begin
            d = 32'h7FC00000;
            fl = 3'b100;
        end else if (e == 255) d = {s, 31'b0};
        else if (e == 0) begin
            d = {s, 8'hFF, 23'b0};
            fl = 3'b010;
        end else begin
            if (x[22:0] == 0) begin
                be = 254 - e;
                m = '0;
            end else begin
                p = 0;
                for (int i = 0; i < 24; i++) if (cd[i]) p = i;
                be = p + 231 - e;
                m = cd << (23 - p);
            end
            if (be <= 0) begin
                d = {s, 31'b0};
                fl = 3'b001;
            end else d = {s, 8'(be), m[22:0]};
        end
    endtask
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        cmp++;
        if (act !== exp) begin
            fail++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask
    // One clock step: update the scoreboard from the handshakes, then check any valid output.
    task automatic tick;
        logic acc, pop, rs;
        logic [31:0] x, d;
        logic [2:0] fl;
        logic [23:0] cd;
        rs = RST;
        acc = !RST && CE && in_valid && in_ready;
        pop = !RST && CE && out_valid && out_ready;
        x = in_data;
        cd = force_en ? force_val : core_recip({1'b1, in_data[22:0]});
        @(posedge CLK);
        if (rs) begin
            qd.delete();
            qf.delete();
        end else begin
            if (pop && qd.size() > 0) begin
                void'(qd.pop_front());
                void'(qf.pop_front());
            end
            if (acc) begin
                model(x, cd, d, fl);
                qd.push_back(d);
                qf.push_back(fl);
            end
        end
        #1;
        if (out_valid) begin
            cmp++;
            if (qd.size() == 0) begin
                fail++;
                $display("FAIL monitor: unexpected out_valid data=%h", out_data);
            end else if (out_data !== qd[0] || out_flags !== qf[0]) begin
                fail++;
                $display("FAIL monitor: got %h/%b required %h/%b", out_data, out_flags, qd[0], qf[0]);
            end
        end
    endtask
    task automatic send(input logic [31:0] x);
        int n;
        n = 0;
        in_data = x;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            tick;
            n++;
        end
        chk("send in_ready", 32'(in_ready), 32'd1);
        tick;
        in_valid = 1'b0;
    endtask
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            tick;
            lat++;
        end
    endtask
    task automatic run(input string nm, input logic [31:0] x, input int lat_exp, input logic [31:0] d_exp, input logic [2:0] f_exp);
        int lat;
        send(x);
        wait_valid(lat);
        chk({nm, " latency"}, 32'(lat), 32'(lat_exp));
        chk({nm, " data"}, out_data, d_exp);
        chk({nm, " flags"}, 32'(out_flags), 32'(f_exp));
        tick;
    endtask
    initial begin
        int lat;
        repeat (3) tick;
        RST = 1'b0;
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_data", out_data, 32'h0);
        chk("reset out_flags", 32'(out_flags), 32'd0);
        chk("reset core_din", 32'(core_din), 32'h0);
        chk("reset core_nrst", 32'(core_nrst), 32'd0);
        send(32'h40000000);
        wait_valid(lat);
        chk("2.0 latency", 32'(lat), 32'd1);
        chk("2.0 data", out_data, 32'h3F000000);
        chk("2.0 core_nrst", 32'(core_nrst), 32'd0);
        tick;
        send(32'h40400000);
        chk("3.0 core_din", 32'(core_din), 32'hC00000);
        chk("3.0 core_nrst", 32'(core_nrst), 32'd1);
        chk("3.0 in_ready", 32'(in_ready), 32'd0);
        wait_valid(lat);
        chk("3.0 latency", 32'(lat), 32'(LAT + 1));
        chk("3.0 data", out_data, 32'h3EAAAAAA);
        chk("3.0 flags", 32'(out_flags), 32'd0);
        tick;
        run("-0", 32'h80000000, 1, 32'hFF800000, 3'b010);
        run("nan", 32'h7FC12345, 1, 32'h7FC00000, 3'b100);
        run("+inf", 32'h7F800000, 1, 32'h00000000, 3'b000);
        run("-inf", 32'hFF800000, 1, 32'h80000000, 3'b000);
        run("denorm", 32'h00000001, 1, 32'h7F800000, 3'b010);
        run("e254 f!=0", 32'h7F400000, LAT + 1, 32'h00000000, 3'b001);
        run("e254 f=0", 32'h7F000000, 1, 32'h00000000, 3'b001);
        run("1.0", 32'h3F800000, 1, 32'h3F800000, 3'b000);
        run("-3.0", 32'hC0400000, LAT + 1, 32'hBEAAAAAA, 3'b000);
        run("min normal", 32'h00800000, 1, 32'h7E800000, 3'b000);
        run("1.5*2^-126", 32'h00C00000, LAT + 1, 32'h7E2AAAAA, 3'b000);
        force_en = 1'b1;
        force_val = 24'h800000;
        run("core msb set", 32'h40400000, LAT + 1, 32'h3F000000, 3'b000);
        force_en = 1'b0;
        out_ready = 1'b0;
        send(32'h40400000);
        in_data = 32'h40000000;
        in_valid = 1'b1;
        wait_valid(lat);
        chk("bp latency", 32'(lat), 32'(LAT + 1));
        for (int i = 0; i < 5; i++) begin
            chk("bp in_ready", 32'(in_ready), 32'd0);
            chk("bp hold data", out_data, 32'h3EAAAAAA);
            chk("bp hold valid", 32'(out_valid), 32'd1);
            tick;
        end
        out_ready = 1'b1;
        tick;
        chk("bp drop valid", 32'(out_valid), 32'd0);
        chk("bp ready again", 32'(in_ready), 32'd1);
        tick;
        in_valid = 1'b0;
        chk("bp second data", out_data, 32'h3F000000);
        chk("bp second valid", 32'(out_valid), 32'd1);
        tick;
        send(32'h40400000);
        lat = 1;
        tick;
        lat++;
        CE = 1'b0;
        repeat (3) begin
            tick;
            lat++;
        end
        CE = 1'b1;
        while (!out_valid && lat < 100) begin
            tick;
            lat++;
        end
        chk("ce latency", 32'(lat), 32'(LAT + 4));
        chk("ce data", out_data, 32'h3EAAAAAA);
        tick;
        send(32'h40400000);
        tick;
        RST = 1'b1;
        tick;
        chk("rst run valid", 32'(out_valid), 32'd0);
        chk("rst run ready", 32'(in_ready), 32'd1);
        chk("rst run nrst", 32'(core_nrst), 32'd0);
        RST = 1'b0;
        repeat (LAT + 2) tick;
        chk("rst run no result", 32'(out_valid), 32'd0);
        run("after rst", 32'h40000000, 1, 32'h3F000000, 3'b000);
        out_ready = 1'b0;
        send(32'h40000000);
        RST = 1'b1;
        tick;
        chk("rst done valid", 32'(out_valid), 32'd0);
        chk("rst done data", out_data, 32'h0);
        RST = 1'b0;
        out_ready = 1'b1;
        tick;
        chk("queue drained", 32'(qd.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fail);
        $finish;
    end
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
